window_stack_ctrl: RTL and testbench
====================================

# window_stack_ctrl

Window controller that sits directly upstream of the register file and drives its 2-bit `window` select. It holds the current window register and a 4-deep return stack, so call/return instructions switch windows and restore them. Direct window-set instructions are also supported. Overflow and underflow are reported as sticky flags for the controller/exception logic.

## Interface
- `DEPTH`, 4: return-stack entries. Fixed at 4 for this design; the depth counter is 3 bits.
- `WW`, 2: window index width. Must match the register file `window` input.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `en` input 1: advance enable. 0 = processor stalled; all state holds and every request is ignored.
- `winSet` input 1: direct-set request; load `winData` into the window.
- `winData` input WW: target window for `winSet`.
- `call` input 1: push the current window and advance to the next window.
- `ret` input 1: pop the stack into the window.
- `window` output WW: current window, registered. Wires straight to the register file `window` input.
- `retWindow` output WW: stack top entry. Value is 0 when `depth` == 0.
- `depth` output 3: number of valid stack entries, 0..4.
- `overflow` output 1: sticky; set by a `call` with the stack full.
- `underflow` output 1: sticky; set by a `ret` with the stack empty.

## Operation
- State: `window` register, stack array `stk[0..3]` of WW bits, `depth` counter, two sticky flags.
- Requests are evaluated only when `en`=1 and `rst`=0. Priority is `winSet` > `call` > `ret`. Lower-priority requests in the same cycle are dropped silently and raise no flag.
- `winSet`: `window` <= `winData`. Stack and `depth` unchanged.
- `call`, `depth` < 4:
  - `stk[depth]` <= `window`.
  - `depth` <= `depth`+1.
  - `window` <= `window`+1, modulo 4 (11 wraps to 00).
- `call`, `depth` == 4: no push; `window` and `depth` unchanged; `overflow` <= 1.
- `ret`, `depth` > 0: `window` <= `stk[depth-1]`; `depth` <= `depth`-1.
- `ret`, `depth` == 0: `window` and `depth` unchanged; `underflow` <= 1.
- `retWindow` = `stk[depth-1]` combinationally when `depth` > 0, else 0.
- Sticky flags clear only on `rst`.
- No request, or `en`=0: all state holds.
- Stack entries above `depth` are don't-care and are never visible on any output.

## Timing
- Reset values, one cycle after `rst` is sampled high: `window`=00, `depth`=0, `retWindow`=00, `overflow`=0, `underflow`=0. Stack contents are zeroed.
- `rst` overrides `en` and all requests in the same cycle. Reset mid-sequence discards all stack contents.
- Latency is one cycle. A request sampled at edge N is reflected on `window`/`depth` right after edge N.
  - The instruction issuing `call`/`ret`/`winSet` still reads and writes registers in the old window.
  - The next instruction uses the new window.
- No handshake; requests are single-cycle pulses. A request held high for k enabled cycles acts k times (e.g. `call` held 2 cycles advances the window by 2).
- Back-to-back `call` then `ret` on consecutive cycles restores the original window after the second edge.
- Window wrap-around is pure modulo arithmetic. It is not an error, independent of `depth`.

## Test plan
- Reset check: hold `rst`=1 with `call`=1 for 2 cycles -> `window`=00, `depth`=0, both flags 0. Nothing is pushed.
- Call/return nesting: from window 00, `call` ×3 -> `window`=11, `depth`=3, `retWindow`=10. Then `ret` ×3 -> `window` 10, 01, 00 in successive cycles; `depth`=0.
- Overflow and wrap:
  - `winSet` `winData`=10, then `call` ×4 -> `window` 11, 00, 01, 10; `depth`=4.
  - Fifth `call` -> `window` stays 10, `depth`=4, `overflow`=1.
  - `overflow` stays 1 through subsequent `ret`s until `rst`.
- Underflow: after reset, `ret` -> `underflow`=1, `window`=00, `depth`=0. A following `call` works normally: `window`=01, `depth`=1.
- Priority and stall:
  - At `depth`=1, `window`=01: `winSet`(`winData`=11) + `call` + `ret` in one cycle -> `window`=11, `depth`=1.
  - Then `en`=0 with `call`=1 for 3 cycles -> no change.

Source files
------------

// File: rtl/window_stack_ctrl.sv
// Register-window controller: current window select plus a 4-deep return stack
// for call/return, with direct window set and sticky overflow/underflow flags.
module window_stack_ctrl #(
  parameter int DEPTH = 4,
  parameter int WW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          winSet,
  input  logic [WW-1:0] winData,
  input  logic          call,
  input  logic          ret,
  output logic [WW-1:0] window,
  output logic [WW-1:0] retWindow,
  output logic [2:0]    depth,
  output logic          overflow,
  output logic          underflow
);

  logic [WW-1:0] r_window;
  logic [WW-1:0] r_stk [DEPTH];
  logic [2:0]    r_depth;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_full;
  logic          w_empty;
  logic [1:0]    w_top_idx;
  logic [1:0]    w_push_idx;

  assign w_full     = (r_depth == 3'(DEPTH));
  assign w_empty    = (r_depth == 3'd0);
  assign w_top_idx  = 2'(r_depth - 3'd1);
  assign w_push_idx = r_depth[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_window    <= '0;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stk[i] <= '0;
    end else if (en) begin
      // Priority winSet > call > ret; losers are dropped without flagging.
      if (winSet) begin
        r_window <= winData;
      end else if (call) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_stk[w_push_idx] <= r_window;
          r_depth           <= r_depth + 3'd1;
          r_window          <= r_window + WW'(1);
        end
      end else if (ret) begin
        if (w_empty) begin
          r_underflow <= 1'b1;
        end else begin
          r_window <= r_stk[w_top_idx];
          r_depth  <= r_depth - 3'd1;
        end
      end
    end
  end

  assign window    = r_window;
  assign retWindow = w_empty ? '0 : r_stk[w_top_idx];
  assign depth     = r_depth;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_window_stack_ctrl.sv
// Directed bench for window_stack_ctrl: reset, nesting, overflow/wrap,
// underflow, priority and stall, with hand-computed expectations.
module tb_window_stack_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       winSet;
  logic [1:0] winData;
  logic       call;
  logic       ret;
  logic [1:0] window;
  logic [1:0] retWindow;
  logic [2:0] depth;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  window_stack_ctrl #(.DEPTH(4), .WW(2)) dut (
    .clk(clk), .rst(rst), .en(en), .winSet(winSet), .winData(winData),
    .call(call), .ret(ret), .window(window), .retWindow(retWindow),
    .depth(depth), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic ws, input logic [1:0] wd,
                      input logic c, input logic rt);
    rst = r; en = e; winSet = ws; winData = wd; call = c; ret = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] w, input logic [2:0] d,
                         input logic [1:0] rw, input logic ov, input logic un);
    chk({tag, ".window"},    8'(window),    8'(w));
    chk({tag, ".depth"},     8'(depth),     8'(d));
    chk({tag, ".retWindow"}, 8'(retWindow), 8'(rw));
    chk({tag, ".overflow"},  8'(overflow),  8'(ov));
    chk({tag, ".underflow"}, 8'(underflow), 8'(un));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; winSet = 1'b0; winData = 2'b00; call = 1'b0; ret = 1'b0;
    #1;

    // Reset held with call asserted: nothing pushed
    step(1, 1, 0, 2'b00, 1, 0);
    step(1, 1, 0, 2'b00, 1, 0);
    chk_all("reset", 2'b00, 3'd0, 2'b00, 0, 0);

    // Call nesting x3 then return x3
    step(0, 1, 0, 2'b00, 1, 0); chk("nest_c1.window", 8'(window), 8'h1);
    step(0, 1, 0, 2'b00, 1, 0); chk("nest_c2.window", 8'(window), 8'h2);
    step(0, 1, 0, 2'b00, 1, 0);
    chk_all("nest_c3", 2'b11, 3'd3, 2'b10, 0, 0);
    step(0, 1, 0, 2'b00, 0, 1); chk_all("nest_r1", 2'b10, 3'd2, 2'b01, 0, 0);
    step(0, 1, 0, 2'b00, 0, 1); chk_all("nest_r2", 2'b01, 3'd1, 2'b00, 0, 0);
    step(0, 1, 0, 2'b00, 0, 1); chk_all("nest_r3", 2'b00, 3'd0, 2'b00, 0, 0);

    // Direct set then overflow with wrap: pushes 2,3,0,1
    step(0, 1, 1, 2'b10, 0, 0); chk_all("set10", 2'b10, 3'd0, 2'b00, 0, 0);
    step(0, 1, 0, 2'b00, 1, 0); chk_all("ov_c1", 2'b11, 3'd1, 2'b10, 0, 0);
    step(0, 1, 0, 2'b00, 1, 0); chk_all("ov_c2", 2'b00, 3'd2, 2'b11, 0, 0);
    step(0, 1, 0, 2'b00, 1, 0); chk_all("ov_c3", 2'b01, 3'd3, 2'b00, 0, 0);
    step(0, 1, 0, 2'b00, 1, 0); chk_all("ov_c4", 2'b10, 3'd4, 2'b01, 0, 0);
    step(0, 1, 0, 2'b00, 1, 0); chk_all("ov_c5", 2'b10, 3'd4, 2'b01, 1, 0);
    step(0, 1, 0, 2'b00, 0, 1); chk_all("ov_r1", 2'b01, 3'd3, 2'b00, 1, 0);
    step(0, 1, 0, 2'b00, 0, 1); chk_all("ov_r2", 2'b00, 3'd2, 2'b11, 1, 0);

    // Mid-sequence reset clears flags and stack
    step(1, 1, 0, 2'b00, 0, 0); chk_all("rst2", 2'b00, 3'd0, 2'b00, 0, 0);

    // Underflow, then normal call
    step(0, 1, 0, 2'b00, 0, 1); chk_all("un_r", 2'b00, 3'd0, 2'b00, 0, 1);
    step(0, 1, 0, 2'b00, 1, 0); chk_all("un_c", 2'b01, 3'd1, 2'b00, 0, 1);

    // All three requests at once: winSet wins
    step(0, 1, 1, 2'b11, 1, 1); chk_all("prio", 2'b11, 3'd1, 2'b00, 0, 1);

    // Stall with call held
    step(0, 0, 0, 2'b00, 1, 0); chk_all("stall1", 2'b11, 3'd1, 2'b00, 0, 1);
    step(0, 0, 0, 2'b00, 1, 0); chk_all("stall2", 2'b11, 3'd1, 2'b00, 0, 1);
    step(0, 0, 1, 2'b01, 1, 1); chk_all("stall3", 2'b11, 3'd1, 2'b00, 0, 1);

    // Back-to-back call then ret restores window
    step(0, 1, 0, 2'b00, 1, 0); chk_all("bb_c", 2'b00, 3'd2, 2'b11, 0, 1);
    step(0, 1, 0, 2'b00, 0, 1); chk_all("bb_r", 2'b11, 3'd1, 2'b00, 0, 1);

    step(0, 1, 0, 2'b00, 0, 0); chk_all("idle", 2'b11, 3'd1, 2'b00, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
